// File: rtl/centroid_writeback.sv
// Copies the final k-means centroids plus a status word into the register file
// after each done pulse, then holds a level interrupt until the host clears it.
module centroid_writeback #(
   parameter int addrWidth         = 9,
   parameter int dataWidth         = 91,
   parameter int centroid_num      = 8,
   parameter int log2_cent_num     = 3,
   parameter int iter_width        = 16,
   parameter int centroid_base_reg = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              done,
   input  logic                              converged,
   input  logic                              aborted,
   input  logic [iter_width-1:0]             iter_count,
   input  logic [centroid_num*dataWidth-1:0] centroids,
   input  logic                              reg_ready,
   input  logic                              int_clr,
   output logic [addrWidth-1:0]              reg_num,
   output logic                              reg_w_r,
   output logic [dataWidth-1:0]              reg_write_data,
   output logic                              busy,
   output logic                              interuptt
);

   typedef enum logic [1:0] {IDLE, WR_CENT, WR_STAT, DONE} state_t;

   localparam logic [addrWidth-1:0]     BaseReg   = addrWidth'(centroid_base_reg);
   localparam logic [addrWidth-1:0]     StatReg   = addrWidth'(centroid_base_reg + centroid_num);
   localparam logic [log2_cent_num-1:0] LastIndex = log2_cent_num'(centroid_num - 1);

   if (centroid_base_reg + centroid_num >= (1 << addrWidth)) begin : g_reg_range_check
      $error("centroid_writeback: status register index does not fit in addrWidth");
   end
   if (iter_width + 2 > dataWidth) begin : g_status_width_check
      $error("centroid_writeback: status word does not fit in dataWidth");
   end

   state_t                   state;
   logic [log2_cent_num-1:0] index;
   logic [log2_cent_num-1:0] next_index;
   logic [dataWidth-1:0]     snap [centroid_num];
   logic                     snap_conv;
   logic                     snap_abort;
   logic [iter_width-1:0]    snap_iter;
   logic [dataWidth-1:0]     status_word;
   logic                     start;

   assign next_index  = index + 1'b1;
   assign status_word = dataWidth'({snap_abort, snap_conv, snap_iter});
   // A new result is only accepted when no snapshot is being written out.
   assign start       = done && (state == IDLE || state == DONE);

   // All outputs are registered so that each transfer word appears together with its address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         index          <= '0;
         snap_conv      <= 1'b0;
         snap_abort     <= 1'b0;
         snap_iter      <= '0;
         reg_num        <= '0;
         reg_w_r        <= 1'b0;
         reg_write_data <= '0;
         busy           <= 1'b0;
         interuptt      <= 1'b0;
         for (int k = 0; k < centroid_num; k++) begin
            snap[k] <= '0;
         end
      end else if (start) begin
         for (int k = 0; k < centroid_num; k++) begin
            snap[k] <= centroids[k*dataWidth +: dataWidth];
         end
         snap_conv      <= converged;
         snap_abort     <= aborted;
         snap_iter      <= iter_count;
         index          <= '0;
         state          <= WR_CENT;
         reg_w_r        <= 1'b1;
         reg_num        <= BaseReg;
         reg_write_data <= centroids[0 +: dataWidth];
         busy           <= 1'b1;
         interuptt      <= 1'b0;
      end else begin
         case (state)
            WR_CENT: begin
               if (reg_ready) begin
                  index <= next_index;
                  if (index == LastIndex) begin
                     state          <= WR_STAT;
                     reg_num        <= StatReg;
                     reg_write_data <= status_word;
                  end else begin
                     reg_num        <= BaseReg + addrWidth'(next_index);
                     reg_write_data <= snap[next_index];
                  end
               end
            end
            WR_STAT: begin
               if (reg_ready) begin
                  state          <= DONE;
                  reg_w_r        <= 1'b0;
                  reg_num        <= '0;
                  reg_write_data <= '0;
                  busy           <= 1'b0;
                  interuptt      <= 1'b1;
               end
            end
            DONE: begin
               if (int_clr) begin
                  state     <= IDLE;
                  interuptt <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_centroid_writeback.sv
// Self-checking bench for centroid_writeback: observed register-file writes are
// collected by a monitor and compared with a list built from the captured inputs.
module tb_centroid_writeback;

   localparam int AW   = 9;
   localparam int DW   = 91;
   localparam int CN   = 8;
   localparam int IW   = 16;
   localparam int BASE = 4;

   typedef struct {
      logic [AW-1:0] num;
      logic [DW-1:0] data;
   } wr_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             done = 1'b0;
   logic             converged = 1'b0;
   logic             aborted = 1'b0;
   logic [IW-1:0]    iter_count = '0;
   logic [CN*DW-1:0] centroids = '0;
   logic             reg_ready = 1'b1;
   logic             int_clr = 1'b0;
   logic [AW-1:0]    reg_num;
   logic             reg_w_r;
   logic [DW-1:0]    reg_write_data;
   logic             busy;
   logic             interuptt;

   int  tests_run = 0;
   int  failures  = 0;
   wr_t obs_q[$];
   wr_t exp_q[$];

   centroid_writeback dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .done           (done),
      .converged      (converged),
      .aborted        (aborted),
      .iter_count     (iter_count),
      .centroids      (centroids),
      .reg_ready      (reg_ready),
      .int_clr        (int_clr),
      .reg_num        (reg_num),
      .reg_w_r        (reg_w_r),
      .reg_write_data (reg_write_data),
      .busy           (busy),
      .interuptt      (interuptt)
   );

   always #5 clk = ~clk;

   // Inputs only change 1ns after a rising edge, so the falling edge sees what the next edge will accept.
   always @(negedge clk) begin
      if (rst_n) begin
         if (reg_w_r && reg_ready) begin
            obs_q.push_back('{num: reg_num, data: reg_write_data});
         end
         if (!reg_w_r) begin
            tests_run++;
            if (reg_num !== '0 || reg_write_data !== '0) begin
               failures++;
               $display("[TB] FAIL idle_zero: reg_num=%0h data=%0h, required 0 and 0", reg_num, reg_write_data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [95:0] w;
      w = {$urandom, $urandom, $urandom};
      return w[DW-1:0];
   endfunction

   function automatic logic [CN*DW-1:0] rand_bus();
      logic [CN*DW-1:0] b;
      for (int k = 0; k < CN; k++) b[k*DW +: DW] = rand_word();
      return b;
   endfunction

   // Reference: centroid k goes to register BASE+k, then the status word to BASE+CN.
   task automatic push_expected(input logic [CN*DW-1:0] bus, input logic conv, input logic abrt,
                                input logic [IW-1:0] it);
      logic [DW-1:0] status;
      for (int k = 0; k < CN; k++) exp_q.push_back('{num: AW'(BASE + k), data: bus[k*DW +: DW]});
      status = DW'(it) + DW'(conv) * DW'(65536) + DW'(abrt) * DW'(131072);
      exp_q.push_back('{num: AW'(BASE + CN), data: status});
   endtask

   // Drives a one-cycle done pulse that the design is expected to capture.
   task automatic pulse_done(input logic [CN*DW-1:0] bus, input logic conv, input logic abrt,
                             input logic [IW-1:0] it);
      done = 1'b1; centroids = bus; converged = conv; aborted = abrt; iter_count = it;
      push_expected(bus, conv, abrt, it);
      tick();
      done = 1'b0;
   endtask

   task automatic wait_int(input bit rand_ready, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (interuptt) begin
            ok = 1'b1;
            break;
         end
         if (rand_ready) reg_ready = 1'($urandom_range(0, 1));
         tick();
      end
      reg_ready = 1'b1;
   endtask

   task automatic clear_queues();
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [CN*DW-1:0] bus;
      bit ok;
      #2 rst_n = 1'b0;
      #20;
      tests_run++;
      if (reg_num !== '0 || reg_w_r !== 1'b0 || reg_write_data !== '0 || busy !== 1'b0 || interuptt !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_state: num=%0h w_r=%b data=%0h busy=%b int=%b, required all 0",
                  reg_num, reg_w_r, reg_write_data, busy, interuptt);
      end
      tick();
      rst_n = 1'b1;
      tick();
      clear_queues();
      pulse_done(rand_bus(), 1'b1, 1'b0, IW'($urandom));
      tick(); tick(); tick();
      tests_run++;
      if (reg_num !== AW'(BASE + 3) || reg_w_r !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_mid_index: reg_num=%0d w_r=%b, required %0d and 1", reg_num, reg_w_r, BASE + 3);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (reg_num !== '0 || reg_w_r !== 1'b0 || reg_write_data !== '0 || busy !== 1'b0 || interuptt !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid_outputs: num=%0h w_r=%b data=%0h busy=%b int=%b, required all 0",
                  reg_num, reg_w_r, reg_write_data, busy, interuptt);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      tests_run++;
      if (interuptt !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_no_int: int=%b busy=%b, required 0 and 0", interuptt, busy);
      end
      clear_queues();
      bus = rand_bus();
      pulse_done(bus, 1'b0, 1'b0, IW'($urandom));
      wait_int(1'b0, ok);
      tests_run++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL reset_restart_timeout: interuptt=%b, required 1", interuptt);
      end
      tests_run++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL reset_restart_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (obs_q[i].num !== exp_q[i].num || obs_q[i].data !== exp_q[i].data) begin
            failures++;
            $display("[TB] FAIL reset_restart_write%0d: reg %0d data %0h, required reg %0d data %0h",
                     i, obs_q[i].num, obs_q[i].data, exp_q[i].num, exp_q[i].data);
         end
      end
      int_clr = 1'b1; tick(); int_clr = 1'b0;
   endtask

   task automatic test_basic();
      logic [CN*DW-1:0] bus;
      for (int k = 0; k < CN; k++) bus[k*DW +: DW] = DW'(k + 1);
      clear_queues();
      pulse_done(bus, 1'b1, 1'b0, 16'd17);
      tests_run++;
      if (busy !== 1'b1 || reg_w_r !== 1'b1 || reg_num !== AW'(BASE)) begin
         failures++;
         $display("[TB] FAIL basic_first_write: busy=%b w_r=%b num=%0d, required 1 1 %0d", busy, reg_w_r, reg_num, BASE);
      end
      for (int i = 0; i < 8; i++) tick();
      tests_run++;
      if (interuptt !== 1'b0 || reg_w_r !== 1'b1 || reg_num !== AW'(BASE + CN)) begin
         failures++;
         $display("[TB] FAIL basic_status_cycle: int=%b w_r=%b num=%0d, required 0 1 %0d", interuptt, reg_w_r, reg_num, BASE + CN);
      end
      tick();
      tests_run++;
      if (interuptt !== 1'b1 || busy !== 1'b0 || reg_w_r !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_int_rise: int=%b busy=%b w_r=%b, required 1 0 0", interuptt, busy, reg_w_r);
      end
      tests_run++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL basic_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (obs_q[i].num !== exp_q[i].num || obs_q[i].data !== exp_q[i].data) begin
            failures++;
            $display("[TB] FAIL basic_write%0d: reg %0d data %0h, required reg %0d data %0h",
                     i, obs_q[i].num, obs_q[i].data, exp_q[i].num, exp_q[i].data);
         end
      end
      int_clr = 1'b1; tick(); int_clr = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_queues();
      pulse_done(rand_bus(), 1'b1, 1'b0, IW'($urandom));
      tick(); tick();
      reg_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (reg_w_r !== 1'b1 || reg_num !== AW'(BASE + 2) || reg_write_data !== exp_q[2].data) begin
            failures++;
            $display("[TB] FAIL stall_hold%0d: w_r=%b num=%0d data=%0h, required 1 %0d %0h",
                     i, reg_w_r, reg_num, reg_write_data, BASE + 2, exp_q[2].data);
         end
         tick();
      end
      reg_ready = 1'b1;
      wait_int(1'b0, ok);
      tests_run++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL stall_timeout: interuptt=%b, required 1", interuptt);
      end
      tests_run++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL stall_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (obs_q[i].num !== exp_q[i].num || obs_q[i].data !== exp_q[i].data) begin
            failures++;
            $display("[TB] FAIL stall_write%0d: reg %0d data %0h, required reg %0d data %0h",
                     i, obs_q[i].num, obs_q[i].data, exp_q[i].num, exp_q[i].data);
         end
      end
      int_clr = 1'b1; tick(); int_clr = 1'b0;
   endtask

   task automatic test_done_ignored();
      bit ok;
      clear_queues();
      pulse_done(rand_bus(), 1'b0, 1'b0, IW'($urandom));
      tick(); tick();
      done = 1'b1; centroids = rand_bus(); converged = 1'b1; aborted = 1'b1; iter_count = IW'($urandom);
      tick();
      done = 1'b0; centroids = rand_bus(); converged = 1'b0; aborted = 1'b0;
      tests_run++;
      if (busy !== 1'b1 || reg_w_r !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ignore_busy: busy=%b w_r=%b, required 1 1", busy, reg_w_r);
      end
      wait_int(1'b0, ok);
      tests_run++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL ignore_timeout: interuptt=%b, required 1", interuptt);
      end
      tests_run++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL ignore_count: %0d writes, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (obs_q[i].num !== exp_q[i].num || obs_q[i].data !== exp_q[i].data) begin
            failures++;
            $display("[TB] FAIL ignore_write%0d: reg %0d data %0h, required reg %0d data %0h",
                     i, obs_q[i].num, obs_q[i].data, exp_q[i].num, exp_q[i].data);
         end
      end
      int_clr = 1'b1; tick(); int_clr = 1'b0;
   endtask

   task automatic test_status_and_clear();
      bit ok;
      clear_queues();
      pulse_done(rand_bus(), 1'b0, 1'b1, 16'hFFFF);
      wait_int(1'b0, ok);
      tests_run++;
      if (!ok || obs_q.size() != CN + 1) begin
         failures++;
         $display("[TB] FAIL status_done: int=%b writes=%0d, required 1 and %0d", interuptt, obs_q.size(), CN + 1);
      end else begin
         tests_run++;
         if (obs_q[CN].num !== exp_q[CN].num || obs_q[CN].data !== exp_q[CN].data) begin
            failures++;
            $display("[TB] FAIL status_word: reg %0d data %0h, required reg %0d data %0h",
                     obs_q[CN].num, obs_q[CN].data, exp_q[CN].num, exp_q[CN].data);
         end
      end
      for (int i = 0; i < 3; i++) tick();
      tests_run++;
      if (interuptt !== 1'b1) begin
         failures++;
         $display("[TB] FAIL int_held: interuptt=%b, required 1", interuptt);
      end
      int_clr = 1'b1; tick(); int_clr = 1'b0;
      tests_run++;
      if (interuptt !== 1'b0 || busy !== 1'b0 || reg_w_r !== 1'b0) begin
         failures++;
         $display("[TB] FAIL int_clear: int=%b busy=%b w_r=%b, required 0 0 0", interuptt, busy, reg_w_r);
      end
      int_clr = 1'b1; tick(); int_clr = 1'b0; tick();
      tests_run++;
      if (interuptt !== 1'b0 || reg_w_r !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_clr: int=%b w_r=%b, required 0 0", interuptt, reg_w_r);
      end
      clear_queues();
      pulse_done(rand_bus(), 1'b1, 1'b0, IW'($urandom));
      wait_int(1'b0, ok);
      clear_queues();
      int_clr = 1'b1;
      pulse_done(rand_bus(), 1'b1, 1'b1, IW'($urandom));
      int_clr = 1'b0;
      tests_run++;
      if (!ok || interuptt !== 1'b0 || busy !== 1'b1 || reg_w_r !== 1'b1 || reg_num !== AW'(BASE)) begin
         failures++;
         $display("[TB] FAIL clr_and_done: int=%b busy=%b w_r=%b num=%0d, required 0 1 1 %0d",
                  interuptt, busy, reg_w_r, reg_num, BASE);
      end
      wait_int(1'b0, ok);
      tests_run++;
      if (!ok || obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL clr_and_done_count: int=%b writes=%0d, required 1 and %0d", interuptt, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (obs_q[i].num !== exp_q[i].num || obs_q[i].data !== exp_q[i].data) begin
            failures++;
            $display("[TB] FAIL clr_and_done_write%0d: reg %0d data %0h, required reg %0d data %0h",
                     i, obs_q[i].num, obs_q[i].data, exp_q[i].num, exp_q[i].data);
         end
      end
      int_clr = 1'b1; tick(); int_clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      for (int r = 0; r < 6; r++) begin
         clear_queues();
         pulse_done(rand_bus(), 1'($urandom), 1'($urandom), IW'($urandom));
         int_clr = 1'($urandom);
         wait_int(1'b1, ok);
         int_clr = 1'b0;
         tests_run++;
         if (!ok || obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("[TB] FAIL b2b%0d_count: int=%b writes=%0d, required 1 and %0d", r, interuptt, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i].num !== exp_q[i].num || obs_q[i].data !== exp_q[i].data) begin
               failures++;
               $display("[TB] FAIL b2b%0d_write%0d: reg %0d data %0h, required reg %0d data %0h",
                        r, i, obs_q[i].num, obs_q[i].data, exp_q[i].num, exp_q[i].data);
            end
         end
         int_clr = 1'b1; tick(); int_clr = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_done_ignored();
      test_status_and_clear();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
